// File: rtl/asu_pipe.sv
// Two-stage pipelined add/sub/shl/rol unit; saturating add/sub under `ASU_PIPE_SAT_EN.
// Latency 2 cycles input-to-out_valid, 1 op/cycle; holds at most 2 ops when stalled.
// Backpressure: in_ready drops only when both stages are full and out_ready is low.
module asu_pipe #(
   parameter int WIDTH = 8,
   parameter int SHW   = 3,
   parameter int CNT_W = 16
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [1:0]       mode,
   input  logic [WIDTH-1:0] x,
   input  logic [WIDTH-1:0] y,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [WIDTH-1:0] out,
   output logic             carry,
   output logic [CNT_W-1:0] done_cnt
);

   logic             s1_valid;
   logic             s2_valid;
   logic [WIDTH-1:0] s1_x;
   logic [WIDTH-1:0] s1_y;
   logic [1:0]       s1_mode;
   logic             s1_load;
   logic             s2_load;
   logic             out_xfer;

   logic [SHW-1:0]   sh_amt;
   logic [WIDTH:0]   sum;
   logic [WIDTH:0]   diff;
   logic [WIDTH:0]   shl_ext;
   logic [WIDTH-1:0] rol_res;
   logic [WIDTH-1:0] res;
   logic             res_c;

   assign in_ready  = ~s1_valid | ~s2_valid | out_ready;
   assign s1_load   = in_valid & in_ready;
   assign s2_load   = s1_valid & (~s2_valid | out_ready);
   assign out_valid = s2_valid;
   assign out_xfer  = s2_valid & out_ready;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         s1_valid <= 1'b0;
         s1_x     <= '0;
         s1_y     <= '0;
         s1_mode  <= 2'b00;
      end else begin
         if (s1_load) begin
            s1_valid <= 1'b1;
            s1_x     <= x;
            s1_y     <= y;
            s1_mode  <= mode;
         end else if (s2_load) begin
            s1_valid <= 1'b0;
         end
      end
   end

   // Bit WIDTH of the extended shift is the last bit pushed out (zero for s=0).
   assign sh_amt  = s1_y[SHW-1:0];
   assign sum     = {1'b0, s1_x} + {1'b0, s1_y};
   assign diff    = {1'b0, s1_x} - {1'b0, s1_y};
   assign shl_ext = {1'b0, s1_x} << sh_amt;
   assign rol_res = (s1_x << sh_amt) | (s1_x >> (WIDTH - int'(sh_amt)));

   always_comb begin
      res   = '0;
      res_c = 1'b0;
      case (s1_mode)
         2'b00: begin
`ifdef ASU_PIPE_SAT_EN
            if (sum[WIDTH]) begin
               res   = '1;
               res_c = 1'b1;
            end else begin
               res   = sum[WIDTH-1:0];
               res_c = 1'b0;
            end
`else
            res   = sum[WIDTH-1:0];
            res_c = sum[WIDTH];
`endif
         end
         2'b01: begin
`ifdef ASU_PIPE_SAT_EN
            if (diff[WIDTH]) begin
               res   = '0;
               res_c = 1'b1;
            end else begin
               res   = diff[WIDTH-1:0];
               res_c = 1'b0;
            end
`else
            res   = diff[WIDTH-1:0];
            res_c = diff[WIDTH];
`endif
         end
         2'b10: begin
            res   = shl_ext[WIDTH-1:0];
            res_c = shl_ext[WIDTH];
         end
         default: begin
            res   = rol_res;
            res_c = 1'b0;
         end
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         s2_valid <= 1'b0;
         out      <= '0;
         carry    <= 1'b0;
      end else begin
         if (s2_load) begin
            s2_valid <= 1'b1;
            out      <= res;
            carry    <= res_c;
         end else if (out_xfer) begin
            s2_valid <= 1'b0;
         end
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         done_cnt <= '0;
      end else if (out_xfer) begin
         done_cnt <= done_cnt + CNT_W'(1);
      end
   end

endmodule

// File: doc/asu_pipe.md
Name: asu_pipe

Overview:
- Parametrised, pipelined successor to the 8-bit combinational add/shift unit (ASU).
- Generalised in operand width, with four operations instead of two.
- Adds a two-stage registered datapath with valid/ready handshakes on input and output, plus a completed-operation counter.
- Sits between an operand source and a result consumer; both may stall.

Parameters:
- WIDTH, 8, operand and result width in bits (≥2, power of two).
- SHW, 3, shift-amount width; must equal log2(WIDTH).
- CNT_W, 16, width of the completed-operation counter.

Ports:
- clk  input  1  system clock, rising edge.
- rst_n  input  1  asynchronous active-low reset.
- in_valid  input  1  operands and mode are valid this cycle.
- in_ready  output  1  block accepts operands this cycle.
- mode  input  2  00 add, 01 subtract, 10 shift-left logical, 11 rotate-left.
- x  input  WIDTH  operand A.
- y  input  WIDTH  operand B; low SHW bits are the shift amount in modes 10/11.
- out_valid  output  1  result valid.
- out_ready  input  1  consumer accepts result.
- out  output  WIDTH  result.
- carry  output  1  carry/borrow/shifted-out flag.
- done_cnt  output  CNT_W  number of results consumed since reset.

Behaviour:
- Reset (rst_n low, asynchronous): s1_valid=0, s2_valid=0, out_valid=0, out=0, carry=0, done_cnt=0, in_ready=1 combinationally. Reset in mid-operation discards all in-flight operations.
- Input transfer when in_valid & in_ready. Output transfer when out_valid & out_ready.
- Stage 1 registers x, y and mode on an input transfer.
- Stage 2 computes from the stage-1 registers and registers {carry, out}. out_valid = s2_valid.
- s2_load = s1_valid & (~s2_valid | out_ready).
- s1_load = in_valid & in_ready.
- in_ready = ~s1_valid | ~s2_valid | out_ready (combinational; no combinational path from in_valid).
- s1_valid next state:
  - set by s1_load;
  - otherwise cleared when stage 1 drains into stage 2 (s2_load);
  - load and drain in the same cycle keeps it at 1.
- s2_valid next state:
  - set by s2_load;
  - otherwise cleared on an output transfer.
- Latency: 2 cycles from input transfer to out_valid when unstalled. Throughput: 1 op/cycle.
- Under stall (out_ready=0), at most 2 ops are held. out and carry are stable while out_valid=1 and out_ready=0. Order is strictly preserved.
- Arithmetic, all unsigned, with s = y[SHW-1:0]:
  - add: {carry,out} = x + y, (WIDTH+1)-bit sum.
  - sub: out = (x − y) mod 2^WIDTH; carry = 1 iff x < y (borrow).
  - shl: out = x << s. carry = bit x[WIDTH−s] (last bit shifted out) when s≠0; carry = 0 when s=0.
  - rol: out = rotate-left of x by s; carry = 0.
- y bits above SHW are ignored in shift modes.
- done_cnt increments by 1 on each output transfer and wraps from 2^CNT_W−1 to 0.

Optional Feature:
- Macro ASU_PIPE_SAT_EN.
- When defined:
  - add with carry-out produces out = all ones, carry = 1;
  - sub with borrow produces out = 0, carry = 1;
  - shift modes are unchanged.
- When undefined: wrap-around results exactly as specified in Behaviour.
- Timing and handshake are identical in both builds.

Test Plan:
- WIDTH=8, reset, then mode=00, x=0xFF, y=0x01 with out_ready=1 → 2 cycles later out=0x00, carry=1 (out=0xFF, carry=1 with ASU_PIPE_SAT_EN); done_cnt=1.
- mode=01, x=0x10, y=0x20 → out=0xF0, carry=1 (0x00, carry=1 with SAT). Then x=0x20, y=0x10 → out=0x10, carry=0.
- mode=10, x=0x81, y=0x01 → out=0x02, carry=1. Then y=0x00 → out=0x81, carry=0. Then y=0xF9 (s=1) → out=0x02, carry=1.
- mode=11, x=0x81, y=0x03 → out=0x0C, carry=0. Then back-to-back mixed ops on consecutive cycles → one result per cycle, in order.
- Stall: hold out_ready=0 and offer 3 adds (1+1, 2+2, 3+3).
  - Only 2 are accepted; in_ready=0 on the third.
  - out=0x02 is held stable.
  - Release out_ready → results 0x02, 0x04, 0x06 appear in order; done_cnt=3.
- Assert rst_n=0 asynchronously mid-stall with 2 ops held → out_valid=0 and done_cnt=0 immediately, in_ready=1. No stale result appears after reset release.
